// File: rtl/ram_sized_moc.sv
// Byte-organised data RAM with MFA/MOC handshake, byte/halfword/word accesses and wait states.
// Define RAM_BIG_ENDIAN_EN for big-endian lane order; little-endian otherwise.
module ram_sized_moc #(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Enable,
  input  logic              ReadWrite,
  input  logic [1:0]        Size,
  input  logic              SignExt,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MOC,
  output logic              Err
);

  localparam int unsigned ROWS = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              rw_q;
  size_t             size_q;
  logic              sext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       din_q;

  // Four byte lanes; the byte at address A lives in lane A[1:0], row A[ADDR_W-1:2].
  logic [7:0] mem [4][ROWS];

  logic [ADDR_W-3:0] row;
  logic [1:0]        off;
  logic [1:0]        hi_lane;
  logic [7:0]        rd_b [4];
  logic [7:0]        wd [4];
  logic [3:0]        we;
  logic              fault;
  logic              access_now;
  logic              commit;
  logic [15:0]       hw;
  logic [31:0]       rd_data;

  assign row        = addr_q[ADDR_W-1:2];
  assign off        = addr_q[1:0];
  assign hi_lane    = {off[1], 1'b1};
  assign access_now = (state == S_WAIT) && Enable && (cnt == 4'd0);
  assign commit     = access_now && !rw_q && !fault && !reset;

  always_comb begin
    for (int i = 0; i < 4; i++) rd_b[i] = mem[i][row];
  end

  always_comb begin
    unique case (size_q)
      SZ_BYTE: fault = 1'b0;
      SZ_HALF: fault = off[0];
      SZ_WORD: fault = |off;
      default: fault = 1'b1;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    hw      = '0;
    rd_data = '0;
    unique case (size_q)
      SZ_BYTE: rd_data = {{24{sext_q & rd_b[off][7]}}, rd_b[off]};
      SZ_HALF: begin
`ifdef RAM_BIG_ENDIAN_EN
        hw = {rd_b[off], rd_b[hi_lane]};
`else
        hw = {rd_b[hi_lane], rd_b[off]};
`endif
        rd_data = {{16{sext_q & hw[15]}}, hw};
      end
      SZ_WORD: begin
`ifdef RAM_BIG_ENDIAN_EN
        rd_data = {rd_b[0], rd_b[1], rd_b[2], rd_b[3]};
`else
        rd_data = {rd_b[3], rd_b[2], rd_b[1], rd_b[0]};
`endif
      end
      default: rd_data = '0;
    endcase
  end

  // Lane enables and data for a write; gated by commit so faults never touch memory.
  always_comb begin
    we = '0;
    for (int i = 0; i < 4; i++) wd[i] = '0;
    unique case (size_q)
      SZ_BYTE: begin
        we[off] = 1'b1;
        wd[off] = din_q[7:0];
      end
      SZ_HALF: begin
        we[off]     = 1'b1;
        we[hi_lane] = 1'b1;
`ifdef RAM_BIG_ENDIAN_EN
        wd[off]     = din_q[15:8];
        wd[hi_lane] = din_q[7:0];
`else
        wd[off]     = din_q[7:0];
        wd[hi_lane] = din_q[15:8];
`endif
      end
      SZ_WORD: begin
        we = 4'hf;
        for (int i = 0; i < 4; i++) begin
`ifdef RAM_BIG_ENDIAN_EN
          wd[i] = din_q[8*(3-i) +: 8];
`else
          wd[i] = din_q[8*i +: 8];
`endif
        end
      end
      default: we = '0;
    endcase
  end

  // NOTE: the array has no reset; contents survive reset and only the control path is cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (commit && we[i]) mem[i][row] <= wd[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      MOC     <= 1'b0;
      Err     <= 1'b0;
      DataOut <= '0;
      rw_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          MOC <= 1'b0;
          if (Enable) begin
            rw_q   <= ReadWrite;
            size_q <= size_t'(Size);
            sext_q <= SignExt;
            addr_q <= Address;
            din_q  <= DataIn;
            cnt    <= 4'(WAIT_STATES);
            Err    <= 1'b0;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!Enable) begin
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            state <= S_DONE;
            MOC   <= 1'b1;
            Err   <= fault;
            if (rw_q && !fault) DataOut <= rd_data;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (!Enable) begin
            state <= S_IDLE;
            MOC   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
